cursor_sprite_reader: RTL and testbench

CURSOR_SPRITE_READER -- requirements
Module: cursor_sprite_reader

---
 rtl/cursor_sprite_reader.sv | 99 +++++++++
 tb/tb_cursor_sprite_reader.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_sprite_reader.sv
// Hardware cursor sprite reader: fetches one 16-pixel, 2 bpp row from the cursor ROM at
// each line start and shifts it out, registered, when the beam reaches the cursor column.
module cursor_sprite_reader #(
    parameter int unsigned SHAPE_COUNT = 12,
    parameter int unsigned ROW_WORDS   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        line_start,
    input  logic [9:0]  ypos,
    input  logic        pixel_en,
    input  logic [10:0] xpos,
    input  logic [10:0] cursor_x,
    input  logic [9:0]  cursor_y,
    input  logic [3:0]  cursor_shape,
    input  logic        cursor_visible,
    output logic [8:0]  rom_addr,
    input  logic [15:0] rom_data,
    output logic [1:0]  pixel,
    output logic        pixel_valid
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ADDR0 = 3'd1;
    localparam logic [2:0] ADDR1 = 3'd2;
    localparam logic [2:0] CAPT1 = 3'd3;
    localparam logic [2:0] READY = 3'd4;
    localparam logic [2:0] SHIFT = 3'd5;

    logic [2:0]  state;
    logic [31:0] line_buf;
    logic [3:0]  pix_idx;
    logic [9:0]  row;
    logic        hit;
    logic [8:0]  row_addr;
    logic        emit;

    // A row above the cursor wraps to a large unsigned value, so one compare covers both edges.
    always_comb begin
        row      = ypos - cursor_y;
        hit      = cursor_visible && ({28'd0, cursor_shape} < SHAPE_COUNT) && (row < 10'd16);
        row_addr = {cursor_shape, 5'd0} + 9'(row[3:0]) * 9'(ROW_WORDS);
        emit     = !line_start && pixel_en &&
                   ((state == READY && xpos == cursor_x) || state == SHIFT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rom_addr <= 9'd0;
            line_buf <= 32'd0;
            pix_idx  <= 4'd0;
        end else if (line_start) begin
            pix_idx <= 4'd0;
            if (hit) begin
                state    <= ADDR0;
                rom_addr <= row_addr;
            end else begin
                state    <= IDLE;
                line_buf <= 32'd0;
            end
        end else begin
            case (state)
                ADDR0: begin
                    rom_addr <= rom_addr + 9'd1;
                    state    <= ADDR1;
                end
                ADDR1: begin
                    line_buf[31:16] <= rom_data;
                    state           <= CAPT1;
                end
                CAPT1: begin
                    line_buf[15:0] <= rom_data;
                    state          <= READY;
                end
                READY, SHIFT: begin
                    if (emit) begin
                        line_buf <= {line_buf[29:0], 2'b00};
                        pix_idx  <= pix_idx + 4'd1;
                        state    <= (pix_idx == 4'd15) ? IDLE : SHIFT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pixel 0 always sits in the top two bits of the line buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel       <= 2'b00;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= emit;
            pixel       <= emit ? line_buf[31:30] : 2'b00;
        end
    end

endmodule

// File: tb/tb_cursor_sprite_reader.sv
// Bench for cursor_sprite_reader: directed table, corner sequences and random lines checked
// against a queue-based model of which ROM pixels each line must produce.
module tb_cursor_sprite_reader;

    logic        clk;
    logic        reset_n;
    logic        line_start;
    logic [9:0]  ypos;
    logic        pixel_en;
    logic [10:0] xpos;
    logic [10:0] cursor_x;
    logic [9:0]  cursor_y;
    logic [3:0]  cursor_shape;
    logic        cursor_visible;
    logic [8:0]  rom_addr;
    logic [15:0] rom_data;
    logic [1:0]  pixel;
    logic        pixel_valid;

    logic [15:0] rom [0:383];

    int total = 0;
    int bad = 0;
    int vcount = 0;
    int since = 100;
    bit started = 0;
    logic [1:0] q[$];
    logic [1:0] seen[$];

    typedef struct {
        logic [3:0] shape;
        logic       vis;
        logic [9:0] dy;
        logic [8:0] addr;
        int         cnt;
    } vec_t;
    vec_t vecs[8];

    cursor_sprite_reader dut (
        .clk(clk), .reset_n(reset_n), .line_start(line_start), .ypos(ypos),
        .pixel_en(pixel_en), .xpos(xpos), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .cursor_shape(cursor_shape), .cursor_visible(cursor_visible),
        .rom_addr(rom_addr), .rom_data(rom_data), .pixel(pixel), .pixel_valid(pixel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= (rom_addr < 9'd384) ? rom[rom_addr] : 16'h0000;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: the model decides what the outputs must show after this edge, then compares.
    task automatic step(input bit ls, input bit pe, input logic [10:0] xp);
        logic       exp_v;
        logic [1:0] exp_p;
        logic [9:0] row;
        logic [15:0] w;
        int base;
        line_start = ls;
        pixel_en   = pe;
        xpos       = xp;
        exp_v = 1'b0;
        exp_p = 2'b00;
        if (ls) begin
            row = ypos - cursor_y;
            q.delete();
            since   = 0;
            started = 0;
            if (cursor_visible && cursor_shape < 4'd12 && row < 10'd16) begin
                base = int'(cursor_shape) * 32 + int'(row) * 2;
                for (int i = 0; i < 16; i++) begin
                    w = rom[base + i / 8];
                    q.push_back(w[15 - 2 * (i % 8) -: 2]);
                end
            end
        end else begin
            since++;
            if (pe && q.size() > 0 && (started || (since >= 4 && xp == cursor_x))) begin
                exp_v   = 1'b1;
                exp_p   = q.pop_front();
                started = 1;
            end
        end
        @(posedge clk);
        #1;
        check("pixel_valid", 32'(pixel_valid), 32'(exp_v));
        check("pixel", 32'(pixel), 32'(exp_p));
        if (pixel_valid === 1'b1) begin
            vcount++;
            seen.push_back(pixel);
        end
        line_start = 1'b0;
        pixel_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 11'd0);
    endtask

    task automatic sweep(input int start_off, input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 11'(int'(cursor_x) - start_off + i));
    endtask

    task automatic setline(input logic [3:0] s, input logic v, input logic [9:0] cy,
                           input logic [9:0] dy, input logic [10:0] cx);
        cursor_shape   = s;
        cursor_visible = v;
        cursor_y       = cy;
        ypos           = cy + dy;
        cursor_x       = cx;
        vcount         = 0;
        seen.delete();
    endtask

    initial begin
        int len;
        int dens;
        bit pe;
        logic [10:0] x;
        logic [8:0] prev;

        reset_n = 1'b0; line_start = 1'b0; pixel_en = 1'b0; xpos = 11'd0; ypos = 10'd0;
        cursor_x = 11'd0; cursor_y = 10'd0; cursor_shape = 4'd0; cursor_visible = 1'b0;
        for (int i = 0; i < 384; i++) rom[i] = 16'($urandom);
        rom[0] = 16'h6000;
        rom[1] = 16'h0000;

        vecs[0] = '{4'd0,  1'b1, 10'd0,   9'd0,   16};
        vecs[1] = '{4'd11, 1'b1, 10'd15,  9'd382, 16};
        vecs[2] = '{4'd5,  1'b1, 10'd3,   9'd166, 16};
        vecs[3] = '{4'd3,  1'b1, 10'd16,  9'd0,   0};
        vecs[4] = '{4'd4,  1'b0, 10'd2,   9'd0,   0};
        vecs[5] = '{4'd12, 1'b1, 10'd0,   9'd0,   0};
        vecs[6] = '{4'd15, 1'b1, 10'd1,   9'd0,   0};
        vecs[7] = '{4'd2,  1'b1, 10'h3FF, 9'd0,   0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(pixel_valid), 0);
        check("reset_pixel", 32'(pixel), 0);
        check("reset_addr", 32'(rom_addr), 0);
        reset_n = 1'b1;

        // Basic row: 0x6000 gives 01, 10 then fourteen transparent pixels.
        setline(4'd0, 1'b1, 10'd100, 10'd0, 11'd50);
        step(1'b1, 1'b0, 11'd0);
        check("basic_addr0", 32'(rom_addr), 0);
        step(1'b0, 1'b0, 11'd0);
        check("basic_addr1", 32'(rom_addr), 1);
        idle(3);
        sweep(5, 30);
        check("basic_count", vcount, 16);
        if (seen.size() >= 2) begin
            check("basic_p0", 32'(seen[0]), 1);
            check("basic_p1", 32'(seen[1]), 2);
        end else begin
            total++;
            bad++;
            $display("FAIL basic_seq: got %0d pixels expected 16", seen.size());
        end

        foreach (vecs[k]) begin
            setline(vecs[k].shape, vecs[k].vis, 10'(200 + 37 * k), vecs[k].dy, 11'(100 + 7 * k));
            prev = rom_addr;
            step(1'b1, 1'b0, 11'd0);
            check("tbl_addr0", 32'(rom_addr), (vecs[k].cnt != 0) ? 32'(vecs[k].addr) : 32'(prev));
            step(1'b0, 1'b0, 11'd0);
            check("tbl_addr1", 32'(rom_addr), (vecs[k].cnt != 0) ? 32'(vecs[k].addr) + 1 : 32'(prev));
            idle(3);
            sweep(4, 28);
            check("tbl_count", vcount, vecs[k].cnt);
        end

        // Earliest drawable column match: fourth cycle after line_start.
        setline(4'd6, 1'b1, 10'd20, 10'd4, 11'd60);
        step(1'b1, 1'b0, 11'd0);
        idle(3);
        sweep(0, 20);
        check("ready_edge_count", vcount, 16);

        // Column match one cycle too early: cursor skipped on this line.
        setline(4'd1, 1'b1, 10'd40, 10'd5, 11'd30);
        step(1'b1, 1'b0, 11'd0);
        idle(2);
        sweep(0, 25);
        check("early_count", vcount, 0);

        // pixel_en gaps inside SHIFT.
        setline(4'd7, 1'b1, 10'd500, 10'd9, 11'd300);
        step(1'b1, 1'b0, 11'd0);
        idle(4);
        for (int i = 0; i < 60; i++) step(1'b0, (i % 3) == 0, 11'(300 + i / 3));
        check("gap_count", vcount, 16);

        // line_start two cycles after another: new row address, old row dropped.
        setline(4'd2, 1'b1, 10'd600, 10'd3, 11'd80);
        step(1'b1, 1'b0, 11'd0);
        step(1'b0, 1'b0, 11'd0);
        ypos = cursor_y + 10'd8;
        step(1'b1, 1'b0, 11'd0);
        check("restart_addr0", 32'(rom_addr), 80);
        step(1'b0, 1'b0, 11'd0);
        check("restart_addr1", 32'(rom_addr), 81);
        idle(3);
        sweep(2, 24);
        check("restart_count", vcount, 16);

        // line_start during SHIFT aborts the remaining pixels.
        setline(4'd8, 1'b1, 10'd700, 10'd0, 11'd90);
        step(1'b1, 1'b0, 11'd0);
        idle(3);
        sweep(0, 6);
        cursor_visible = 1'b0;
        step(1'b1, 1'b1, 11'd96);
        sweep(-7, 20);
        check("abort_count", vcount, 6);

        // Asynchronous reset in the middle of SHIFT.
        setline(4'd9, 1'b1, 10'd300, 10'd12, 11'd400);
        step(1'b1, 1'b0, 11'd0);
        idle(3);
        sweep(0, 5);
        #3 reset_n = 1'b0;
        #1;
        check("rst_valid", 32'(pixel_valid), 0);
        check("rst_pixel", 32'(pixel), 0);
        q.delete();
        started = 0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        sweep(10, 30);
        check("post_rst_count", vcount, 5);
        setline(4'd9, 1'b1, 10'd300, 10'd12, 11'd400);
        step(1'b1, 1'b0, 11'd0);
        idle(3);
        sweep(0, 20);
        check("first_line_after_rst", vcount, 16);

        // Random lines; short or sparse lines get cut off by the next line_start.
        for (int l = 0; l < 40; l++) begin
            len  = $urandom_range(20, 60);
            dens = $urandom_range(1, 4);
            setline(4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0), 10'($urandom),
                    10'($urandom_range(0, 19)), 11'($urandom_range(20, 1900)));
            step(1'b1, 1'b0, 11'd0);
            x = cursor_x - 11'($urandom_range(0, 8));
            for (int i = 0; i < len; i++) begin
                pe = ($urandom_range(0, dens - 1) == 0);
                step(1'b0, pe, x);
                if (pe) x = x + 11'd1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
